// File: rtl/cpu_bus_responder_pkg.sv
// Shared types and constants for the CPU bus responder.
// The timeout read value is only returned when CPU_BUS_WAIT_EN is defined.
package cpu_bus_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } busState_e;

    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/cpu_bus_responder.sv
// Bridges a strobe-based CPU bus onto a single-request memory port.
// Optional wait-state support with timeout is enabled by defining CPU_BUS_WAIT_EN.
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Address_Out,
    input  logic [ADDR_W-1:0] i_Address,
    input  logic              i_Bus_In,
    input  logic              i_Bus_Out,
    input  logic [7:0]        i_Data_Write,
    output logic [7:0]        o_Data_Read,
    output logic              o_Data_Valid,
    output logic              o_Stall,
    output logic              o_Protocol_Err,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_Req,
    output logic              o_Mem_We,
    output logic [7:0]        o_Mem_Wdata,
    input  logic [7:0]        i_Mem_Rdata,
    input  logic              i_Mem_Ready
);

    busState_e         state_q,     state_d;
    logic [ADDR_W-1:0] memAddr_q,   memAddr_d;
    logic              memReq_q,    memReq_d;
    logic              memWe_q,     memWe_d;
    logic [7:0]        memWdata_q,  memWdata_d;
    logic [7:0]        dataRead_q,  dataRead_d;
    logic              dataValid_q, dataValid_d;
    logic              protoErr_q,  protoErr_d;

    logic dataStrobe;
    logic accessOk;
    logic timedOut;

    assign dataStrobe = i_Bus_In | i_Bus_Out;

`ifdef CPU_BUS_WAIT_EN
    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              stallNow;

    // Counts consecutive not-ready ACCESS cycles; the last permitted one times out.
    assign stallNow = (state_q == ST_ACCESS) && !i_Mem_Ready;
    assign accessOk = i_Mem_Ready;
    assign timedOut = stallNow && (waitCnt_q == WAIT_LAST);
    assign o_Stall  = stallNow;

    always_comb begin
        waitCnt_d = '0;
        if (stallNow && !timedOut) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end
`else
    logic unusedWaitCfg;

    assign accessOk      = 1'b1;
    assign timedOut      = 1'b0;
    assign o_Stall       = 1'b0;
    assign unusedWaitCfg = i_Mem_Ready ^ (WAIT_MAX != 0);
`endif

    always_comb begin
        state_d     = state_q;
        memAddr_d   = memAddr_q;
        memReq_d    = memReq_q;
        memWe_d     = memWe_q;
        memWdata_d  = memWdata_q;
        dataRead_d  = dataRead_q;
        dataValid_d = 1'b0;
        protoErr_d  = protoErr_q;

        case (state_q)
            ST_IDLE: begin
                if (dataStrobe) begin
                    protoErr_d = 1'b1;
                end
                if (i_Address_Out) begin
                    memAddr_d = i_Address;
                    state_d   = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (i_Bus_In && i_Bus_Out) begin
                    protoErr_d = 1'b1;
                end else if (i_Bus_In) begin
                    memReq_d = 1'b1;
                    memWe_d  = 1'b0;
                    state_d  = ST_ACCESS;
                end else if (i_Bus_Out) begin
                    memReq_d   = 1'b1;
                    memWe_d    = 1'b1;
                    memWdata_d = i_Data_Write;
                    state_d    = ST_ACCESS;
                end else if (i_Address_Out) begin
                    memAddr_d = i_Address;
                end
            end

            // Request, address and write data stay frozen until completion.
            ST_ACCESS: begin
                if (i_Address_Out || dataStrobe) begin
                    protoErr_d = 1'b1;
                end
                if (accessOk || timedOut) begin
                    memReq_d = 1'b0;
                    memWe_d  = 1'b0;
                    state_d  = ST_DONE;
                    if (timedOut) begin
                        protoErr_d = 1'b1;
                    end
                    if (!memWe_q) begin
                        dataRead_d  = accessOk ? i_Mem_Rdata : TIMEOUT_RDATA;
                        dataValid_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (dataStrobe) begin
                    protoErr_d = 1'b1;
                end
                if (i_Address_Out) begin
                    memAddr_d = i_Address;
                    state_d   = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            memAddr_q   <= '0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memWdata_q  <= 8'h00;
            dataRead_q  <= 8'h00;
            dataValid_q <= 1'b0;
            protoErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            memAddr_q   <= memAddr_d;
            memReq_q    <= memReq_d;
            memWe_q     <= memWe_d;
            memWdata_q  <= memWdata_d;
            dataRead_q  <= dataRead_d;
            dataValid_q <= dataValid_d;
            protoErr_q  <= protoErr_d;
        end
    end

    assign o_Mem_Addr     = memAddr_q;
    assign o_Mem_Req      = memReq_q;
    assign o_Mem_We       = memWe_q;
    assign o_Mem_Wdata    = memWdata_q;
    assign o_Data_Read    = dataRead_q;
    assign o_Data_Valid   = dataValid_q;
    assign o_Protocol_Err = protoErr_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed self-checking bench for cpu_bus_responder; read results go through a scoreboard queue.
// Wait-state and timeout steps run only when CPU_BUS_WAIT_EN is defined.
module tb_cpu_bus_responder;

    localparam int ADDR_W = 16;

    logic              i_Clk = 1'b0;
    logic              i_Reset;
    logic              i_Address_Out;
    logic [ADDR_W-1:0] i_Address;
    logic              i_Bus_In;
    logic              i_Bus_Out;
    logic [7:0]        i_Data_Write;
    logic [7:0]        o_Data_Read;
    logic              o_Data_Valid;
    logic              o_Stall;
    logic              o_Protocol_Err;
    logic [ADDR_W-1:0] o_Mem_Addr;
    logic              o_Mem_Req;
    logic              o_Mem_We;
    logic [7:0]        o_Mem_Wdata;
    logic [7:0]        i_Mem_Rdata;
    logic              i_Mem_Ready;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } readExp_t;

    readExp_t expQ[$];
    readExp_t expHead;
    int       checks   = 0;
    int       errors   = 0;
    int       cycleCnt = 0;

    cpu_bus_responder #(
        .ADDR_W   (ADDR_W),
        .WAIT_MAX (15)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Address_Out  (i_Address_Out),
        .i_Address      (i_Address),
        .i_Bus_In       (i_Bus_In),
        .i_Bus_Out      (i_Bus_Out),
        .i_Data_Write   (i_Data_Write),
        .o_Data_Read    (o_Data_Read),
        .o_Data_Valid   (o_Data_Valid),
        .o_Stall        (o_Stall),
        .o_Protocol_Err (o_Protocol_Err),
        .o_Mem_Addr     (o_Mem_Addr),
        .o_Mem_Req      (o_Mem_Req),
        .o_Mem_We       (o_Mem_We),
        .o_Mem_Wdata    (o_Mem_Wdata),
        .i_Mem_Rdata    (i_Mem_Rdata),
        .i_Mem_Ready    (i_Mem_Ready)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic tickN(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic addrOut, input logic [ADDR_W-1:0] addr,
                                 input logic busIn, input logic busOut, input logic [7:0] wdata);
        i_Address_Out = addrOut;
        i_Address     = addr;
        i_Bus_In      = busIn;
        i_Bus_Out     = busOut;
        i_Data_Write  = wdata;
    endtask

    task automatic expectRead(input logic [7:0] data, input int latency);
        readExp_t e;
        e.data  = data;
        e.cycle = cycleCnt + latency;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        tick();
    endtask

    // Every read-data pulse must match the oldest outstanding expectation, data and timing.
    always @(negedge i_Clk) begin
        if (o_Data_Valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", {31'd0, o_Data_Valid}, 32'd0);
            end else begin
                expHead = expQ.pop_front();
                checkOutput("read_data", {24'd0, o_Data_Read}, {24'd0, expHead.data});
                checkOutput("read_cycle", cycleCnt, expHead.cycle);
            end
        end
    end

    initial begin
        i_Reset     = 1'b1;
        i_Mem_Rdata = 8'h00;
        i_Mem_Ready = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
        tickN(2);

        checkOutput("rst_data_read", {24'd0, o_Data_Read}, 32'h00);
        checkOutput("rst_valid", {31'd0, o_Data_Valid}, 32'd0);
        checkOutput("rst_stall", {31'd0, o_Stall}, 32'd0);
        checkOutput("rst_err", {31'd0, o_Protocol_Err}, 32'd0);
        checkOutput("rst_req", {31'd0, o_Mem_Req}, 32'd0);
        checkOutput("rst_we", {31'd0, o_Mem_We}, 32'd0);
        checkOutput("rst_addr", {16'd0, o_Mem_Addr}, 32'd0);
        checkOutput("rst_wdata", {24'd0, o_Mem_Wdata}, 32'd0);

        i_Reset     = 1'b0;
        i_Mem_Ready = 1'b1;
        tick();
        checkOutput("idle_ready_ignored", {31'd0, o_Data_Valid}, 32'd0);

        // Zero-wait read.
        applyStimulus(1'b1, 16'hC000, 1'b0, 1'b0, 8'h00);
        tick();
        i_Mem_Rdata = 8'h5A;
        applyStimulus(1'b0, 16'hC000, 1'b1, 1'b0, 8'h00);
        expectRead(8'h5A, 2);
        tick();
        applyStimulus(1'b0, 16'hC000, 1'b0, 1'b0, 8'h00);
        checkOutput("rd_req", {31'd0, o_Mem_Req}, 32'd1);
        checkOutput("rd_we", {31'd0, o_Mem_We}, 32'd0);
        checkOutput("rd_addr", {16'd0, o_Mem_Addr}, 32'hC000);
        tick();
        checkOutput("rd_valid", {31'd0, o_Data_Valid}, 32'd1);
        checkOutput("rd_req_drop", {31'd0, o_Mem_Req}, 32'd0);
        checkOutput("rd_err", {31'd0, o_Protocol_Err}, 32'd0);
        tick();
        checkOutput("rd_valid_pulse", {31'd0, o_Data_Valid}, 32'd0);

        // Write leaves the read data alone.
        applyStimulus(1'b1, 16'hFF80, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 16'hFF80, 1'b0, 1'b1, 8'h3C);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("wr_req", {31'd0, o_Mem_Req}, 32'd1);
        checkOutput("wr_we", {31'd0, o_Mem_We}, 32'd1);
        checkOutput("wr_addr", {16'd0, o_Mem_Addr}, 32'hFF80);
        checkOutput("wr_wdata", {24'd0, o_Mem_Wdata}, 32'h3C);
        tick();
        checkOutput("wr_req_drop", {31'd0, o_Mem_Req}, 32'd0);
        checkOutput("wr_data_read_kept", {24'd0, o_Data_Read}, 32'h5A);
        checkOutput("wr_no_valid", {31'd0, o_Data_Valid}, 32'd0);
        tick();

        // Back-to-back reads: new address issued in the DONE cycle.
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 8'h00);
        tick();
        i_Mem_Rdata = 8'h11;
        applyStimulus(1'b0, 16'h0010, 1'b1, 1'b0, 8'h00);
        expectRead(8'h11, 2);
        tick();
        applyStimulus(1'b0, 16'h0010, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 8'h00);
        tick();
        i_Mem_Rdata = 8'h22;
        applyStimulus(1'b0, 16'h0020, 1'b1, 1'b0, 8'h00);
        expectRead(8'h22, 2);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("b2b_addr", {16'd0, o_Mem_Addr}, 32'h0020);
        tickN(2);

`ifdef CPU_BUS_WAIT_EN
        // Three wait states, then ready.
        i_Mem_Ready = 1'b0;
        i_Mem_Rdata = 8'hA7;
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 16'h1234, 1'b1, 1'b0, 8'h00);
        expectRead(8'hA7, 5);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ws_stall", {31'd0, o_Stall}, 32'd1);
            checkOutput("ws_req", {31'd0, o_Mem_Req}, 32'd1);
            checkOutput("ws_addr", {16'd0, o_Mem_Addr}, 32'h1234);
            tick();
        end
        i_Mem_Ready = 1'b1;
        #1;
        checkOutput("ws_stall_release", {31'd0, o_Stall}, 32'd0);
        tick();
        checkOutput("ws_req_drop", {31'd0, o_Mem_Req}, 32'd0);
        tick();

        // Memory never answers: timeout after 15 stalled cycles.
        i_Mem_Ready = 1'b0;
        applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 16'h2000, 1'b1, 1'b0, 8'h00);
        expectRead(8'hFF, 16);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            checkOutput("to_stall", {31'd0, o_Stall}, 32'd1);
            tick();
        end
        checkOutput("to_err", {31'd0, o_Protocol_Err}, 32'd1);
        checkOutput("to_req_drop", {31'd0, o_Mem_Req}, 32'd0);
        checkOutput("to_data_ff", {24'd0, o_Data_Read}, 32'hFF);
        checkOutput("to_stall_drop", {31'd0, o_Stall}, 32'd0);
        i_Mem_Ready = 1'b1;
        doReset();
`else
        // Without wait support ACCESS lasts one cycle even with ready low.
        i_Mem_Ready = 1'b0;
        i_Mem_Rdata = 8'hA7;
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 16'h1234, 1'b1, 1'b0, 8'h00);
        expectRead(8'hA7, 2);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("nw_stall", {31'd0, o_Stall}, 32'd0);
        tick();
        checkOutput("nw_req_drop", {31'd0, o_Mem_Req}, 32'd0);
        tick();
        i_Mem_Ready = 1'b1;
`endif

        // Data strobe in IDLE.
        checkOutput("pre_viol_err", {31'd0, o_Protocol_Err}, 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("idle_strobe_err", {31'd0, o_Protocol_Err}, 32'd1);
        checkOutput("idle_strobe_noreq", {31'd0, o_Mem_Req}, 32'd0);
        tick();
        checkOutput("idle_strobe_noreq2", {31'd0, o_Mem_Req}, 32'd0);
        doReset();
        checkOutput("reset_clears_err", {31'd0, o_Protocol_Err}, 32'd0);

        // Both strobes in ADDR: flagged, state kept so a clean read still works.
        applyStimulus(1'b1, 16'h3000, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 16'h3000, 1'b1, 1'b1, 8'h55);
        tick();
        checkOutput("both_err", {31'd0, o_Protocol_Err}, 32'd1);
        checkOutput("both_noreq", {31'd0, o_Mem_Req}, 32'd0);
        i_Mem_Rdata = 8'h66;
        applyStimulus(1'b0, 16'h3000, 1'b1, 1'b0, 8'h00);
        expectRead(8'h66, 2);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("both_then_read_req", {31'd0, o_Mem_Req}, 32'd1);
        tickN(4);
        checkOutput("err_sticky", {31'd0, o_Protocol_Err}, 32'd1);
        doReset();

        // Address strobe during ACCESS is flagged and ignored.
        applyStimulus(1'b1, 16'h4000, 1'b0, 1'b0, 8'h00);
        tick();
        i_Mem_Rdata = 8'h77;
        applyStimulus(1'b0, 16'h4000, 1'b1, 1'b0, 8'h00);
        expectRead(8'h77, 2);
        tick();
        applyStimulus(1'b1, 16'h5000, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("acc_addr_err", {31'd0, o_Protocol_Err}, 32'd1);
        checkOutput("acc_addr_kept", {16'd0, o_Mem_Addr}, 32'h4000);
        tick();
        doReset();

        // Reset in the middle of an access.
        i_Mem_Ready = 1'b0;
        applyStimulus(1'b1, 16'h6000, 1'b0, 1'b0, 8'h00);
        tick();
        i_Mem_Rdata = 8'h99;
        applyStimulus(1'b0, 16'h6000, 1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
        checkOutput("mid_req_before", {31'd0, o_Mem_Req}, 32'd1);
        i_Reset = 1'b1;
        #1;
        checkOutput("mid_req", {31'd0, o_Mem_Req}, 32'd0);
        checkOutput("mid_addr", {16'd0, o_Mem_Addr}, 32'd0);
        checkOutput("mid_stall", {31'd0, o_Stall}, 32'd0);
        checkOutput("mid_data_read", {24'd0, o_Data_Read}, 32'd0);
        tick();
        i_Reset     = 1'b0;
        i_Mem_Ready = 1'b1;
        tickN(3);
        checkOutput("mid_no_valid", {31'd0, o_Data_Valid}, 32'd0);
        checkOutput("mid_no_req", {31'd0, o_Mem_Req}, 32'd0);

        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
